// File: rtl/sap_1_controller_sequencer_if.sv
// Control-word bus between the SAP-1 controller-sequencer and the datapath.
// The controller drives the ring state and control lines and reads the IR opcode.
interface sap_1_controller_sequencer_if;
    logic [3:0] opcode;
    logic [5:0] T;
    logic       Cp;
    logic       Ep;
    logic       Lm;
    logic       CE;
    logic       Li;
    logic       Ei;
    logic       La;
    logic       Ea;
    logic       SU;
    logic       EU;
    logic       Lb;
    logic       Lo;
    logic       HLT;

    modport master (
        input  opcode,
        output T, Cp, Ep, Lm, CE, Li, Ei, La, Ea, SU, EU, Lb, Lo, HLT
    );

    modport slave (
        output opcode,
        input  T, Cp, Ep, Lm, CE, Li, Ei, La, Ea, SU, EU, Lb, Lo, HLT
    );
endinterface

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring plus opcode decode of the control word.
// Define SAP_1_CONTROLLER_HLT_EN to make opcode 1111 freeze the ring at T4 until CLR.
module sap_1_controller_sequencer (
    input  logic                                CLK,
    input  logic                                CLR,
    sap_1_controller_sequencer_if.master        bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    t_state_e state;
    logic     halted;

    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

`ifdef SAP_1_CONTROLLER_HLT_EN
    logic halt_req;
    assign halt_req = (state == T4) && (bus.opcode == OP_HLT);
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= T1;
`ifdef SAP_1_CONTROLLER_HLT_EN
            halted <= 1'b0;
`endif
        end else if (!halted) begin
`ifdef SAP_1_CONTROLLER_HLT_EN
            // Halt latches at the T4 edge and the ring parks on T4.
            if (halt_req) begin
                halted <= 1'b1;
                state  <= T4;
            end else begin
`endif
                case (state)
                    T1:      state <= T2;
                    T2:      state <= T3;
                    T3:      state <= T4;
                    T4:      state <= T5;
                    T5:      state <= T6;
                    T6:      state <= T1;
                    default: state <= T1;
                endcase
`ifdef SAP_1_CONTROLLER_HLT_EN
            end
`endif
        end
    end

    // Control word is a pure decode of the registered ring and the IR opcode.
    always_comb begin
        cp  = 1'b0;
        ep  = 1'b0;
        lm  = 1'b0;
        ce  = 1'b0;
        li  = 1'b0;
        ei  = 1'b0;
        la  = 1'b0;
        ea  = 1'b0;
        su  = 1'b0;
        eu  = 1'b0;
        lb  = 1'b0;
        lo  = 1'b0;
        hlt = 1'b0;
        if (!CLR && halted) begin
            hlt = 1'b1;
        end else if (!CLR) begin
            case (state)
                T1: begin
                    ep = 1'b1;
                    lm = 1'b1;
                end
                T2: cp = 1'b1;
                T3: begin
                    ce = 1'b1;
                    li = 1'b1;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ei = 1'b1;
                            lm = 1'b1;
                        end
                        OP_OUT: begin
                            ea = 1'b1;
                            lo = 1'b1;
                        end
`ifdef SAP_1_CONTROLLER_HLT_EN
                        OP_HLT: hlt = 1'b1;
`endif
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ce = 1'b1;
                            la = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ce = 1'b1;
                            lb = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        la = 1'b1;
                        eu = 1'b1;
                        su = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.T   = state;
    assign bus.Cp  = cp;
    assign bus.Ep  = ep;
    assign bus.Lm  = lm;
    assign bus.CE  = ce;
    assign bus.Li  = li;
    assign bus.Ei  = ei;
    assign bus.La  = la;
    assign bus.Ea  = ea;
    assign bus.SU  = su;
    assign bus.EU  = eu;
    assign bus.Lb  = lb;
    assign bus.Lo  = lo;
    assign bus.HLT = hlt;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer: fetch, each opcode class, halt and mid-instruction clear.
module tb_sap_1_controller_sequencer;

    logic CLK;
    logic CLR;
    int   tests;
    int   failed;

    sap_1_controller_sequencer_if bus ();

    sap_1_controller_sequencer dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control-word bit masks, ordered {Cp,Ep,Lm,CE,Li,Ei,La,Ea,SU,EU,Lb,Lo}.
    localparam logic [11:0] M_CP = 12'h800;
    localparam logic [11:0] M_EP = 12'h400;
    localparam logic [11:0] M_LM = 12'h200;
    localparam logic [11:0] M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080;
    localparam logic [11:0] M_EI = 12'h040;
    localparam logic [11:0] M_LA = 12'h020;
    localparam logic [11:0] M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008;
    localparam logic [11:0] M_EU = 12'h004;
    localparam logic [11:0] M_LB = 12'h002;
    localparam logic [11:0] M_LO = 12'h001;

    localparam logic [5:0] S1 = 6'b000001;
    localparam logic [5:0] S2 = 6'b000010;
    localparam logic [5:0] S3 = 6'b000100;
    localparam logic [5:0] S4 = 6'b001000;
    localparam logic [5:0] S5 = 6'b010000;
    localparam logic [5:0] S6 = 6'b100000;

    function automatic logic [11:0] cw();
        return {bus.Cp, bus.Ep, bus.Lm, bus.CE, bus.Li, bus.Ei,
                bus.La, bus.Ea, bus.SU, bus.EU, bus.Lb, bus.Lo};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp_t,
                         input logic [11:0] exp_w, input logic exp_h);
        logic [11:0] w;
        logic [4:0]  drv;
        w   = cw();
        drv = {bus.Ep, bus.CE, bus.Ei, bus.Ea, bus.EU};
        tests++;
        assert (bus.T === exp_t) else begin
            failed++;
            $error("FAIL %s.T observed %b expected %b", tag, bus.T, exp_t);
        end
        tests++;
        assert (w === exp_w) else begin
            failed++;
            $error("FAIL %s.word observed %h expected %h", tag, w, exp_w);
        end
        tests++;
        assert (bus.HLT === exp_h) else begin
            failed++;
            $error("FAIL %s.HLT observed %b expected %b", tag, bus.HLT, exp_h);
        end
        tests++;
        assert ($countones(drv) <= 1) else begin
            failed++;
            $error("FAIL %s.bus_excl observed %b expected at most one driver", tag, drv);
        end
    endtask

    // Starts at a T1 sample point; leaves the ring back at the next T1 sample point.
    task automatic run_instr(input string tag, input logic [3:0] op,
                             input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
        check({tag, "_t1"}, S1, M_EP | M_LM, 1'b0);
        tick();
        check({tag, "_t2"}, S2, M_CP, 1'b0);
        tick();
        check({tag, "_t3"}, S3, M_CE | M_LI, 1'b0);
        bus.opcode = op;
        tick();
        check({tag, "_t4"}, S4, w4, 1'b0);
        tick();
        check({tag, "_t5"}, S5, w5, 1'b0);
        tick();
        check({tag, "_t6"}, S6, w6, 1'b0);
        tick();
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        CLR        = 1'b1;
        bus.opcode = 4'b0000;

        tick();
        check("rst_edge1", S1, 12'h000, 1'b0);
        tick();
        check("rst_edge2", S1, 12'h000, 1'b0);
        CLR = 1'b0;
        #1;
        check("rst_release", S1, M_EP | M_LM, 1'b0);

        run_instr("lda", 4'b0000, M_EI | M_LM, M_CE | M_LA, 12'h000);
        check("lda_wrap", S1, M_EP | M_LM, 1'b0);
        run_instr("sub", 4'b0010, M_EI | M_LM, M_CE | M_LB, M_LA | M_EU | M_SU);
        run_instr("add", 4'b0001, M_EI | M_LM, M_CE | M_LB, M_LA | M_EU);
        run_instr("out", 4'b1110, M_EA | M_LO, 12'h000, 12'h000);
        run_instr("nop", 4'b0101, 12'h000, 12'h000, 12'h000);
        check("nop_wrap", S1, M_EP | M_LM, 1'b0);

`ifdef SAP_1_CONTROLLER_HLT_EN
        check("hlt_t1", S1, M_EP | M_LM, 1'b0);
        tick();
        check("hlt_t2", S2, M_CP, 1'b0);
        tick();
        check("hlt_t3", S3, M_CE | M_LI, 1'b0);
        bus.opcode = 4'b1111;
        tick();
        check("hlt_t4", S4, 12'h000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hlt_hold", S4, 12'h000, 1'b1);
        end
        CLR = 1'b1;
        #1;
        check("hlt_clr_comb", S4, 12'h000, 1'b0);
        tick();
        check("hlt_clr_edge", S1, 12'h000, 1'b0);
        CLR        = 1'b0;
        bus.opcode = 4'b0000;
        #1;
        check("hlt_exit", S1, M_EP | M_LM, 1'b0);
`else
        run_instr("hlt_nop", 4'b1111, 12'h000, 12'h000, 12'h000);
        check("hlt_nop_wrap", S1, M_EP | M_LM, 1'b0);
`endif

        check("clr_t1", S1, M_EP | M_LM, 1'b0);
        tick();
        check("clr_t2", S2, M_CP, 1'b0);
        tick();
        check("clr_t3", S3, M_CE | M_LI, 1'b0);
        bus.opcode = 4'b0001;
        tick();
        check("clr_t4", S4, M_EI | M_LM, 1'b0);
        tick();
        check("clr_t5", S5, M_CE | M_LB, 1'b0);
        CLR = 1'b1;
        #1;
        check("clr_t5_forced", S5, 12'h000, 1'b0);
        tick();
        check("clr_edge", S1, 12'h000, 1'b0);
        CLR = 1'b0;
        #1;
        check("clr_after_t1", S1, M_EP | M_LM, 1'b0);
        tick();
        check("clr_after_t2", S2, M_CP, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
